keypad_scanner: RTL

Scans a 4×4 key matrix by driving one row low at a time and sampling the four column lines. Synchronizes and debounces the columns, then delivers one key code per press through a valid/ack handshake. It is the input-side counterpart of the multiplexed 7-segment display driver: same 27 MHz board clock, same row-strobe time base, but it reads a time-multiplexed matrix instead of driving one. Sits between the board keypad pins and the control logic that consumes entered digits.

---
 rtl/keypad_pkg.sv | 28 ++
 rtl/sync2.sv | 28 ++
 rtl/keypad_scanner.sv | 136 +++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// KEYMAP is indexed by {row, col}; row 3 carries the * / # keys as E / F.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN,
      PRESS_DB,
      HOLD
   } kp_state_t;

   localparam logic [3:0] KEYMAP [16] = '{
      4'h1, 4'h2, 4'h3, 4'hA,
      4'h4, 4'h5, 4'h6, 4'hB,
      4'h7, 4'h8, 4'h9, 4'hC,
      4'hE, 4'h0, 4'hF, 4'hD
   };

   // Lowest-indexed active-low column wins when several keys share a row.
   function automatic logic [1:0] first_low(input logic [3:0] i_col);
      logic [1:0] w_idx;
      w_idx = 2'd3;
      if (!i_col[2]) w_idx = 2'd2;
      if (!i_col[1]) w_idx = 2'd1;
      if (!i_col[0]) w_idx = 2'd0;
      return w_idx;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for asynchronous level inputs.
// Reset value is selectable so pulled-up lines come out of reset idle.
module sync2 #(
   parameter int unsigned        WIDTH   = 1,
   parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [WIDTH-1:0]  i_d,
   output logic [WIDTH-1:0]  o_q
);

   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_meta <= RST_VAL;
         r_sync <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row strobing, debounced press/release detection,
// and a valid/ack handshake with a sticky overrun flag.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int unsigned SCAN_DIV       = 27000,
   parameter int unsigned DEBOUNCE_TICKS = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  col_n,
   output logic [3:0]  row_n,
   output logic [3:0]  key_code,
   output logic        key_valid,
   input  logic        key_ack,
   output logic        overrun
);

   localparam int unsigned TW = $clog2(SCAN_DIV);
   localparam int unsigned DW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(SCAN_DIV - 1);
   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_TICKS - 1);

   logic [3:0]    w_col_s;
   logic          w_tick;
   logic          w_accept;
   logic [TW-1:0] r_tick_cnt;
   kp_state_t     r_state;
   logic [1:0]    r_row;
   logic [3:0]    r_row_n;
   logic [1:0]    r_col;
   logic [DW-1:0] r_db_cnt;
   logic [3:0]    r_key_code;
   logic          r_key_valid;
   logic          r_overrun;

   sync2 #(
      .WIDTH   (4),
      .RST_VAL (4'hF)
   ) u_col_sync (
      .i_clk (clk),
      .i_rst (rst),
      .i_d   (col_n),
      .o_q   (w_col_s)
   );

   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst || w_tick) r_tick_cnt <= '0;
      else               r_tick_cnt <= r_tick_cnt + TW'(1);
   end

   // The pre-increment count is compared, so accept lands on the tick that
   // brings the confirmed-press count up to DEBOUNCE_TICKS.
   always_comb begin
      w_accept = (r_state == PRESS_DB) && w_tick && !w_col_s[r_col]
                 && (r_db_cnt >= DB_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= SCAN;
         r_row       <= 2'd0;
         r_row_n     <= 4'b1110;
         r_col       <= 2'd0;
         r_db_cnt    <= '0;
         r_key_code  <= 4'h0;
         r_key_valid <= 1'b0;
         r_overrun   <= 1'b0;
      end else begin
         if (w_tick) begin
            case (r_state)
               SCAN: begin
                  if (w_col_s != 4'hF) begin
                     r_col    <= first_low(w_col_s);
                     r_db_cnt <= DW'(1);
                     r_state  <= PRESS_DB;
                  end else begin
                     r_row   <= r_row + 2'd1;
                     r_row_n <= {r_row_n[2:0], r_row_n[3]};
                  end
               end
               PRESS_DB: begin
                  if (!w_col_s[r_col]) begin
                     if (r_db_cnt >= DB_LAST) begin
                        r_state  <= HOLD;
                        r_db_cnt <= '0;
                     end else begin
                        r_db_cnt <= r_db_cnt + DW'(1);
                     end
                  end else begin
                     r_state  <= SCAN;
                     r_db_cnt <= '0;
                     r_row    <= r_row + 2'd1;
                     r_row_n  <= {r_row_n[2:0], r_row_n[3]};
                  end
               end
               HOLD: begin
                  if (w_col_s[r_col]) begin
                     if (r_db_cnt >= DB_LAST) begin
                        r_state  <= SCAN;
                        r_db_cnt <= '0;
                        r_row    <= r_row + 2'd1;
                        r_row_n  <= {r_row_n[2:0], r_row_n[3]};
                     end else begin
                        r_db_cnt <= r_db_cnt + DW'(1);
                     end
                  end else begin
                     r_db_cnt <= '0;
                  end
               end
               default: r_state <= SCAN;
            endcase
         end

         // A same-cycle ack frees the slot, so the new key wins without overrun.
         if (w_accept) begin
            if (!r_key_valid || key_ack) begin
               r_key_code  <= KEYMAP[{r_row, r_col}];
               r_key_valid <= 1'b1;
            end else begin
               r_overrun   <= 1'b1;
            end
         end else if (key_ack && r_key_valid) begin
            r_key_valid <= 1'b0;
         end
      end
   end

   assign row_n     = r_row_n;
   assign key_code  = r_key_code;
   assign key_valid = r_key_valid;
   assign overrun   = r_overrun;

endmodule
